// File: rtl/bcd_onehot_decoder.sv
// rtl/bcd_onehot_decoder.sv - packed BCD word to serial one-hot digits, LS digit first
// Illegal codes (10..15) emit an all-zero one-hot with out_err set and are counted.
module bcd_onehot_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [9:0]              out_onehot,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    out_err,
  output logic [7:0]              err_count,
  output logic                    busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] word;
  logic [IDX_W-1:0]        next_idx;
  logic [10:0]             first_dec;
  logic [10:0]             next_dec;

  // Result is {err, onehot}.
  function automatic logic [10:0] decode(input logic [3:0] v);
    logic [10:0] r;
    r = '0;
    if (v < 4'd10) r[9:0] = 10'd1 << v;
    else           r[10]  = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] digit_at(input logic [4*NUM_DIGITS-1:0] w,
                                          input logic [IDX_W-1:0] k);
    logic [3:0] d;
    d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (k == IDX_W'(i)) d = w[4*i +: 4];
    return d;
  endfunction

  assign in_ready  = (state == IDLE);
  assign busy      = (state == EMIT);
  assign next_idx  = out_idx + IDX_W'(1);
  assign first_dec = decode(in_bcd[3:0]);
  assign next_dec  = decode(digit_at(word, next_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word       <= '0;
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word                  <= in_bcd;
            out_idx               <= '0;
            {out_err, out_onehot} <= first_dec;
            out_last              <= (LAST_IDX == '0);
            out_valid             <= 1'b1;
            state                 <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (out_idx == LAST_IDX) begin
              // Word finished: drop valid and park the fields at zero for the IDLE bubble.
              state      <= IDLE;
              out_valid  <= 1'b0;
              out_onehot <= '0;
              out_idx    <= '0;
              out_last   <= 1'b0;
              out_err    <= 1'b0;
            end else begin
              out_idx               <= next_idx;
              {out_err, out_onehot} <= next_dec;
              out_last              <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_onehot_decoder.sv
// tb/tb_bcd_onehot_decoder.sv - self-checking bench for bcd_onehot_decoder
module tb_bcd_onehot_decoder;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4*N-1:0] in_bcd;
  logic         out_valid;
  logic         out_ready;
  logic [9:0]   out_onehot;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         out_err;
  logic [7:0]   err_count;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bcd_onehot_decoder #(.NUM_DIGITS(N), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_idx(out_idx), .out_last(out_last),
    .out_err(out_err), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] oh;
    logic       err;
    int         idx;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   m_cnt   = 0;
  int   hs      = 0;
  int   accepts = 0;

  function automatic exp_t make_entry(input int unsigned w, input int k);
    exp_t e;
    int unsigned v;
    v      = (w / (16 ** k)) % 16;
    e.oh   = (v < 10) ? 10'(1 << v) : 10'd0;
    e.err  = (v >= 10);
    e.idx  = k;
    e.last = (k == N - 1);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes N queued digits; one leaves per accepted handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cnt <= 0;
    end else if (q.size() > 0) begin
      if (out_ready) begin
        if (q[0].err && m_cnt < 255) m_cnt <= m_cnt + 1;
        hs <= hs + 1;
        void'(q.pop_front());
      end
    end else if (in_valid) begin
      for (int k = 0; k < N; k++) q.push_back(make_entry(32'(in_bcd), k));
      accepts <= accepts + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready",  32'(in_ready),  32'(q.size() == 0));
      chk("busy",      32'(busy),      32'(q.size() > 0));
      chk("err_count", 32'(err_count), 32'(m_cnt));
      if (q.size() > 0) begin
        chk("out_onehot", 32'(out_onehot), 32'(q[0].oh));
        chk("out_err",    32'(out_err),    32'(q[0].err));
        chk("out_idx",    32'(out_idx),    32'(q[0].idx));
        chk("out_last",   32'(out_last),   32'(q[0].last));
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(in_ready && !out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
  endtask

  // Called on a negedge while idle; returns on the negedge where digit 0 is visible.
  task automatic send(input logic [15:0] w);
    in_bcd   = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int acc0;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst out_valid",  32'(out_valid),  32'd0);
    chk("rst out_onehot", 32'(out_onehot), 32'd0);
    chk("rst err_count",  32'(err_count),  32'd0);
    chk("rst busy",       32'(busy),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);

    // 1: 16'h1234, continuous out_ready
    send(16'h1234);
    chk("t1 d0", 32'(out_onehot), 32'(10'b0000010000));
    chk("t1 idx0", 32'(out_idx), 32'd0);
    chk("t1 last0", 32'(out_last), 32'd0);
    @(negedge clk); chk("t1 d1", 32'(out_onehot), 32'(10'b0000001000));
    @(negedge clk); chk("t1 d2", 32'(out_onehot), 32'(10'b0000000100));
    @(negedge clk); chk("t1 d3", 32'(out_onehot), 32'(10'b0000000010));
    chk("t1 last3", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("t1 in_ready", 32'(in_ready), 32'd1);
    chk("t1 out_valid", 32'(out_valid), 32'd0);

    // 2: 16'h0909 with out_ready toggling
    hs0 = hs;
    out_ready = 1'b0;
    send(16'h0909);
    chk("t2 d0", 32'(out_onehot), 32'(10'b1000000000));
    for (int i = 0; i < 10; i++) begin
      out_ready = ~out_ready;
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_idle(20);
    chk("t2 handshakes", 32'(hs - hs0), 32'd4);

    // 3: 16'hA5F0, two illegal digits
    send(16'hA5F0);
    chk("t3 d0", 32'({out_err, out_onehot}), 32'({1'b0, 10'b0000000001}));
    @(negedge clk); chk("t3 d1", 32'({out_err, out_onehot}), 32'({1'b1, 10'b0}));
    @(negedge clk); chk("t3 d2", 32'({out_err, out_onehot}), 32'({1'b0, 10'b0000100000}));
    @(negedge clk); chk("t3 d3", 32'({out_err, out_onehot}), 32'({1'b1, 10'b0}));
    @(negedge clk);
    chk("t3 err_count", 32'(err_count), 32'd2);

    // 4: 75 words of 16'hFFFF saturate err_count
    for (int i = 0; i < 75; i++) begin
      send(16'hFFFF);
      wait_idle(20);
      if (i == 59) chk("t4 err_count 242", 32'(err_count), 32'd242);
    end
    chk("t4 err_count sat", 32'(err_count), 32'd255);

    // 5: async reset mid-word after the idx=1 handshake
    send(16'h4321);
    @(negedge clk);
    @(negedge clk);
    chk("t5 idx2", 32'(out_idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 out_valid", 32'(out_valid), 32'd0);
    chk("t5 err_count", 32'(err_count), 32'd0);
    chk("t5 in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h8765);
    chk("t5 new idx0", 32'(out_idx), 32'd0);
    chk("t5 new d0", 32'(out_onehot), 32'(10'b0000100000));
    wait_idle(20);

    // 6: in_valid held high; in_bcd changes during EMIT
    acc0 = accepts;
    in_bcd = 16'h1357;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t6 d0", 32'(out_onehot), 32'(10'b0010000000));
    in_bcd = 16'h2468;
    @(negedge clk);
    chk("t6 d1", 32'(out_onehot), 32'(10'b0000100000));
    n = 0;
    while (accepts < acc0 + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("t6 accepts", 32'(accepts - acc0), 32'd2);
    chk("t6 second d0", 32'(out_onehot), 32'(10'b0100000000));
    wait_idle(20);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
